// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, width helpers and constants for the instruction cache
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        COMMIT
    } fill_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    function automatic int offset_width(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int index_width(input int lines);
        return $clog2(lines);
    endfunction

    // Two low PC bits select a byte within the word and never reach the cache.
    function automatic int tag_width(input int lines, input int words_per_line);
        return 30 - offset_width(words_per_line) - index_width(lines);
    endfunction

endpackage

// File: rtl/icache_fetch_ctrl_if.sv
// rtl/icache_fetch_ctrl_if.sv - fetch-side and backing-memory signals of the instruction cache
// ICACHE_STATS_EN adds the HIT_CNT/MISS_CNT statistics outputs.
interface icache_fetch_ctrl_if;

    logic [31:0] PC;
    logic        RDEN;
    logic        FLUSH;
    logic [31:0] INSTR;
    logic        PC_STALL;
    logic        MEM_REQ;
    logic [31:0] MEM_ADDR;
    logic        MEM_ACK;
    logic [31:0] MEM_RDATA;
`ifdef ICACHE_STATS_EN
    logic [31:0] HIT_CNT;
    logic [31:0] MISS_CNT;
`endif

    modport slave (
        input  PC, RDEN, FLUSH, MEM_ACK, MEM_RDATA,
        output INSTR, PC_STALL, MEM_REQ, MEM_ADDR
`ifdef ICACHE_STATS_EN
        , output HIT_CNT, MISS_CNT
`endif
    );

    modport master (
        output PC, RDEN, FLUSH, MEM_ACK, MEM_RDATA,
        input  INSTR, PC_STALL, MEM_REQ, MEM_ADDR
`ifdef ICACHE_STATS_EN
        , input HIT_CNT, MISS_CNT
`endif
    );

endinterface

// File: rtl/icache_line_store.sv
// rtl/icache_line_store.sv - valid/tag/data arrays with a combinational read port and one write port
module icache_line_store
    import icache_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    localparam int OFF_W = offset_width(WORDS_PER_LINE),
    localparam int IDX_W = index_width(LINES),
    localparam int TAG_W = tag_width(LINES, WORDS_PER_LINE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_index,
    input  logic [OFF_W-1:0] rd_offset,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_word_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [OFF_W-1:0] wr_offset,
    input  logic [31:0]      wr_data,
    input  logic             wr_tag_en,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_valid_set,
    input  logic             flush_all
);

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES*WORDS_PER_LINE];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[{rd_index, rd_offset}];

    // Flush wins over a same-cycle valid set so a fence.i can never be undone by a commit.
    always_comb begin
        valid_d = valid_q;
        if (wr_valid_set) begin
            valid_d[wr_index] = 1'b1;
        end
        if (flush_all) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_word_en) begin
            data_mem[{wr_index, wr_offset}] <= wr_data;
        end
        if (wr_tag_en) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

endmodule

// File: rtl/icache_fetch_ctrl.sv
// rtl/icache_fetch_ctrl.sv - direct-mapped read-only instruction cache with whole-line refill
// ICACHE_STATS_EN adds saturating hit/miss counters.
module icache_fetch_ctrl
    import icache_pkg::*;
#(
    parameter int          LINES          = 16,
    parameter int          WORDS_PER_LINE = 4,
    parameter logic [31:0] RESET_INSTR    = NOP_INSTR
) (
    input logic               CLK,
    input logic               RST,
    icache_fetch_ctrl_if.slave bus
);

    localparam int OFF_W = offset_width(WORDS_PER_LINE);
    localparam int IDX_W = index_width(LINES);
    localparam int TAG_W = tag_width(LINES, WORDS_PER_LINE);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    fill_state_e      state_q, state_d;
    logic             mem_req_q, mem_req_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;
    logic             abandon_q, abandon_d;
    logic [IDX_W-1:0] line_idx_q, line_idx_d;
    logic [TAG_W-1:0] line_tag_q, line_tag_d;

    logic [OFF_W-1:0] pc_off;
    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic             unused_pc_bits;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             hit;
    logic             ack;
    logic [OFF_W-1:0] cnt_inc;
    logic             word_we;
    logic             tag_we;
    logic             valid_set;

    assign pc_off         = bus.PC[OFF_W+1:2];
    assign pc_idx         = bus.PC[OFF_W+IDX_W+1:OFF_W+2];
    assign pc_tag         = bus.PC[31:OFF_W+IDX_W+2];
    assign unused_pc_bits = ^bus.PC[1:0];

    icache_line_store #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_store (
        .clk          (CLK),
        .rst          (RST),
        .rd_index     (pc_idx),
        .rd_offset    (pc_off),
        .rd_valid     (rd_valid),
        .rd_tag       (rd_tag),
        .rd_data      (rd_data),
        .wr_word_en   (word_we),
        .wr_index     (line_idx_q),
        .wr_offset    (cnt_q),
        .wr_data      (bus.MEM_RDATA),
        .wr_tag_en    (tag_we),
        .wr_tag       (line_tag_q),
        .wr_valid_set (valid_set),
        .flush_all    (bus.FLUSH)
    );

    assign hit     = bus.RDEN & rd_valid & (rd_tag == pc_tag) & (state_q == IDLE);
    assign ack     = bus.MEM_ACK & mem_req_q;
    assign cnt_inc = cnt_q + OFF_W'(1);

    // Stall is masked during reset so the fetch stage sees a quiet cache while RST is held.
    assign bus.INSTR    = hit ? rd_data : RESET_INSTR;
    assign bus.PC_STALL = bus.RDEN & ~hit & ~RST;
    assign bus.MEM_REQ  = mem_req_q;
    assign bus.MEM_ADDR = mem_addr_q;

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        cnt_d      = cnt_q;
        abandon_d  = abandon_q;
        line_idx_d = line_idx_q;
        line_tag_d = line_tag_q;
        word_we    = 1'b0;
        tag_we     = 1'b0;
        valid_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.RDEN && !hit) begin
                    state_d    = FILL;
                    line_idx_d = pc_idx;
                    line_tag_d = pc_tag;
                    cnt_d      = '0;
                    abandon_d  = 1'b0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {pc_tag, pc_idx, {OFF_W{1'b0}}, 2'b00};
                end
            end
            FILL: begin
                if (bus.FLUSH) begin
                    abandon_d = 1'b1;
                end
                if (ack) begin
                    word_we = 1'b1;
                    cnt_d   = cnt_inc;
                    if (cnt_q == LAST_WORD) begin
                        mem_req_d = 1'b0;
                        state_d   = COMMIT;
                    end else begin
                        mem_addr_d = {line_tag_q, line_idx_q, cnt_inc, 2'b00};
                    end
                end
            end
            COMMIT: begin
                tag_we    = 1'b1;
                valid_set = ~abandon_q & ~bus.FLUSH;
                state_d   = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            cnt_q      <= '0;
            abandon_q  <= 1'b0;
            line_idx_q <= '0;
            line_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
            abandon_q  <= abandon_d;
            line_idx_q <= line_idx_d;
            line_tag_q <= line_tag_d;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit && !bus.PC_STALL && hit_cnt_q != 32'hFFFF_FFFF) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (state_q == IDLE && state_d == FILL && miss_cnt_q != 32'hFFFF_FFFF) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.HIT_CNT  = hit_cnt_q;
    assign bus.MISS_CNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// tb/tb_icache_fetch_ctrl.sv - directed self-checking bench for icache_fetch_ctrl
module tb_icache_fetch_ctrl;

    localparam int          W   = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    icache_fetch_ctrl_if bus();

    icache_fetch_ctrl #(
        .LINES          (16),
        .WORDS_PER_LINE (W),
        .RESET_INSTR    (NOP)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Entered at the negedge where the miss is visible; returns #1 after the negedge following COMMIT.
    task automatic do_miss(input logic [31:0] pc, input int lat, input int flush_beat);
        logic [31:0] base;
        int          t0;
        int          n;
        base = {pc[31:4], 4'h0};
        t0   = cyc;
        tick;
        bus.MEM_ACK = 1'b0;
        for (int i = 0; i < W; i++) begin
            n = 0;
            while (bus.MEM_REQ !== 1'b1 && n < 20) begin
                tick;
                n++;
            end
            chk("fill_req", {31'd0, bus.MEM_REQ}, 32'd1);
            chk("fill_addr", bus.MEM_ADDR, base + 32'(4 * i));
            chk("fill_stall", {31'd0, bus.PC_STALL}, 32'd1);
            repeat (lat) tick;
            if (lat > 0) chk("addr_hold", bus.MEM_ADDR, base + 32'(4 * i));
            bus.MEM_ACK   = 1'b1;
            bus.MEM_RDATA = mem_word(base + 32'(4 * i));
            if (i == flush_beat) bus.FLUSH = 1'b1;
            tick;
            bus.MEM_ACK   = 1'b0;
            bus.FLUSH     = 1'b0;
            bus.MEM_RDATA = '0;
        end
        #1;
        chk("commit_req", {31'd0, bus.MEM_REQ}, 32'd0);
        chk("commit_stall", {31'd0, bus.PC_STALL}, 32'd1);
        if (flush_beat == W) bus.FLUSH = 1'b1;
        tick;
        bus.FLUSH = 1'b0;
        #1;
        if (flush_beat >= 0) begin
            chk("abandon_stall", {31'd0, bus.PC_STALL}, 32'd1);
            chk("abandon_instr", bus.INSTR, NOP);
        end else begin
            chk("post_fill_stall", {31'd0, bus.PC_STALL}, 32'd0);
            chk("post_fill_instr", bus.INSTR, mem_word(pc));
            if (lat == 0) chk("miss_penalty", 32'(cyc - t0), 32'(W + 2));
        end
    endtask

    task automatic hit_at(input logic [31:0] pc);
        tick;
        bus.PC   = pc;
        bus.RDEN = 1'b1;
        #1;
        chk("hit_stall", {31'd0, bus.PC_STALL}, 32'd0);
        chk("hit_instr", bus.INSTR, mem_word(pc));
        chk("hit_noreq", {31'd0, bus.MEM_REQ}, 32'd0);
    endtask

    initial begin
        bus.PC        = '0;
        bus.RDEN      = 1'b0;
        bus.FLUSH     = 1'b0;
        bus.MEM_ACK   = 1'b0;
        bus.MEM_RDATA = '0;
        tick;
        tick;
        chk("rst_req", {31'd0, bus.MEM_REQ}, 32'd0);
        chk("rst_addr", bus.MEM_ADDR, 32'd0);
        chk("rst_stall", {31'd0, bus.PC_STALL}, 32'd0);
        chk("rst_instr", bus.INSTR, NOP);
        bus.RDEN = 1'b1;
        #1;
        chk("rst_stall_rden", {31'd0, bus.PC_STALL}, 32'd0);
        bus.RDEN = 1'b0;
        tick;
        rst = 1'b0;

        // Cold miss on line 0x0 with two-cycle ACK latency
        bus.RDEN = 1'b1;
        bus.PC   = 32'h0;
        #1;
        chk("cold_stall", {31'd0, bus.PC_STALL}, 32'd1);
        chk("cold_instr", bus.INSTR, NOP);
        do_miss(32'h0, 2, -1);

        // Same-cycle hits, then a stray ACK while idle
        hit_at(32'h8);
        hit_at(32'hC);
        bus.MEM_ACK   = 1'b1;
        bus.MEM_RDATA = 32'hDEAD_BEEF;
        tick;
        bus.MEM_ACK   = 1'b0;
        bus.MEM_RDATA = '0;
        #1;
        chk("stray_ack_req", {31'd0, bus.MEM_REQ}, 32'd0);
        chk("stray_ack_instr", bus.INSTR, mem_word(32'hC));

        // Conflict miss: 0x100 shares index 0 with 0x0
        tick;
        bus.PC = 32'h100;
        #1;
        chk("conflict_stall", {31'd0, bus.PC_STALL}, 32'd1);
        do_miss(32'h100, 2, -1);
        tick;
        bus.PC = 32'h0;
        #1;
        chk("evicted_stall", {31'd0, bus.PC_STALL}, 32'd1);
        do_miss(32'h0, 0, -1);

        // Flush while idle invalidates line 0
        tick;
        bus.RDEN  = 1'b0;
        bus.FLUSH = 1'b1;
        tick;
        bus.FLUSH = 1'b0;
        bus.RDEN  = 1'b1;
        bus.PC    = 32'h0;
        #1;
        chk("flush_stall", {31'd0, bus.PC_STALL}, 32'd1);
        do_miss(32'h0, 1, -1);

        // Flush during FILL, then flush during COMMIT
        tick;
        bus.PC = 32'h40;
        #1;
        do_miss(32'h40, 1, 1);
        do_miss(32'h40, 0, -1);
        tick;
        bus.PC = 32'h80;
        #1;
        do_miss(32'h80, 0, W);
        do_miss(32'h80, 0, -1);

        // Reset after the second ACK of a fill
        tick;
        bus.PC = 32'h4;
        #1;
        chk("pre_rst_stall", {31'd0, bus.PC_STALL}, 32'd1);
        tick;
        chk("rst_fill_addr0", bus.MEM_ADDR, 32'h0);
        bus.MEM_ACK   = 1'b1;
        bus.MEM_RDATA = mem_word(32'h0);
        tick;
        bus.MEM_RDATA = mem_word(32'h4);
        tick;
        bus.MEM_ACK = 1'b0;
        #1;
        chk("rst_fill_addr2", bus.MEM_ADDR, 32'h8);
        rst = 1'b1;
        #1;
        chk("midrst_req", {31'd0, bus.MEM_REQ}, 32'd0);
        chk("midrst_stall", {31'd0, bus.PC_STALL}, 32'd0);
        chk("midrst_addr", bus.MEM_ADDR, 32'd0);
        chk("midrst_instr", bus.INSTR, NOP);
        bus.MEM_ACK = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        #1;
        chk("postrst_stall", {31'd0, bus.PC_STALL}, 32'd1);
        chk("postrst_req", {31'd0, bus.MEM_REQ}, 32'd0);
        do_miss(32'h4, 2, -1);
        bus.RDEN = 1'b0;

        // Three hits after one miss since reset
        hit_at(32'h0);
        hit_at(32'h8);
        hit_at(32'hC);
        tick;
        bus.RDEN = 1'b0;
        #1;
`ifdef ICACHE_STATS_EN
        chk("hit_cnt", bus.HIT_CNT, 32'd3);
        chk("miss_cnt", bus.MISS_CNT, 32'd1);
`endif
        chk("idle_stall", {31'd0, bus.PC_STALL}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
